// File: rtl/wash_pkg.sv
// Shared definitions for the wash program controller: state codes,
// the state enum built on them, and the selectable water temperatures.
package wash_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_HEAT  = 3'd2;
   localparam logic [2:0] S_WASH  = 3'd3;
   localparam logic [2:0] S_RINSE = 3'd4;
   localparam logic [2:0] S_SPIN  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERROR = 3'd7;

   localparam logic [6:0] TEMP_10 = 7'd10;
   localparam logic [6:0] TEMP_30 = 7'd30;
   localparam logic [6:0] TEMP_40 = 7'd40;
   localparam logic [6:0] TEMP_60 = 7'd60;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_FILL  = S_FILL,
      ST_HEAT  = S_HEAT,
      ST_WASH  = S_WASH,
      ST_RINSE = S_RINSE,
      ST_SPIN  = S_SPIN,
      ST_DONE  = S_DONE,
      ST_ERROR = S_ERROR
   } state_t;

   // Phases that hold the door locked and advance the phase timer.
   function automatic logic is_active(state_t s);
      return (s == ST_FILL) || (s == ST_HEAT) || (s == ST_WASH) ||
             (s == ST_RINSE) || (s == ST_SPIN);
   endfunction

endpackage

// File: rtl/wash_cycle_sequencer_tick_prescaler.sv
// Divides clk by TICK_DIV into a one-cycle tick; the count holds while
// enable is low so a paused phase resumes mid-period where it stopped.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = enable && (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash program controller: sequences FILL, HEAT, WASH, RINSE, SPIN with
// per-phase tick timers, door supervision, pause and cancel handling.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start with door closed
// FILL  | inlet valve open until level reached (timed, fault on expiry)
// HEAT  | heating and tumbling until target reached (timed, fault)
// WASH  | tumbling for WASH_TICKS, heater held within hysteresis band
// RINSE | valve open and tumbling for RINSE_TICKS
// SPIN  | drain and high-speed spin for SPIN_TICKS
// DONE  | program finished, door released
// ERROR | fault: drain only, waits for cancel
module wash_cycle_sequencer
   import wash_pkg::*;
#(
   parameter int TICK_DIV     = 1000,
   parameter int FILL_TIMEOUT = 60,
   parameter int HEAT_TIMEOUT = 300,
   parameter int WASH_TICKS   = 600,
   parameter int RINSE_TICKS  = 200,
   parameter int SPIN_TICKS   = 120,
   parameter int HYST         = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       pause,
   input  logic       cancel,
   input  logic       door_closed,
   input  logic       water_level_ok,
   input  logic [6:0] water_temp,
   input  logic [6:0] target_temp,
   output logic       door_lock,
   output logic       fill_valve,
   output logic       heater_on,
   output logic       motor_on,
   output logic       motor_spin,
   output logic       drain_pump,
   output logic       done,
   output logic       error,
   output logic [2:0] state,
   output logic [9:0] remaining
);

   state_t     st_q, st_d;
   logic [9:0] cnt_q, cnt_d;
   logic       cxl_q, cxl_d;
   logic       active, timeout, tick;
   logic [6:0] heat_thr;
   logic       run_d;
   logic       lock_d, fill_d, heat_d, motor_d, spin_d, drain_d;

   assign active  = is_active(st_q);
   assign timeout = ((st_q == ST_FILL) || (st_q == ST_HEAT)) && (cnt_q == '0);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (active && !pause),
      .tick    (tick)
   );

   // Lower edge of the heater band, clamped so small targets never wrap.
   assign heat_thr = (target_temp > 7'(HYST)) ? (target_temp - 7'(HYST)) : 7'd0;

   always_comb begin
      st_d  = st_q;
      cxl_d = cxl_q;
      cnt_d = cnt_q;

      if (active && !door_closed) begin
         st_d = ST_ERROR;
      end else if (timeout) begin
         st_d = ST_ERROR;
      end else if (active && (st_q != ST_SPIN) && (cancel || cxl_q)) begin
         // A cancel seen while paused is remembered until the pause lifts.
         cxl_d = 1'b1;
         if (!pause) st_d = ST_SPIN;
      end else if (!(active && pause)) begin
         case (st_q)
            ST_IDLE:  if (start && door_closed) st_d = ST_FILL;
            ST_FILL:  if (water_level_ok) st_d = ST_HEAT;
            ST_HEAT:  if (water_temp >= target_temp) st_d = ST_WASH;
            ST_WASH:  if (cnt_q == '0) st_d = ST_RINSE;
            ST_RINSE: if (cnt_q == '0) st_d = ST_SPIN;
            ST_SPIN:  if (cnt_q == '0) st_d = ST_DONE;
            ST_DONE: begin
               if (!door_closed)   st_d = ST_IDLE;
               else if (start)     st_d = ST_FILL;
            end
            ST_ERROR: if (cancel) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
         endcase
      end

      if (st_d != st_q) cxl_d = 1'b0;

      if (!is_active(st_d)) begin
         cnt_d = '0;
      end else if (st_d != st_q) begin
         case (st_d)
            ST_FILL:  cnt_d = 10'(FILL_TIMEOUT);
            ST_HEAT:  cnt_d = 10'(HEAT_TIMEOUT);
            ST_WASH:  cnt_d = 10'(WASH_TICKS);
            ST_RINSE: cnt_d = 10'(RINSE_TICKS);
            default:  cnt_d = 10'(SPIN_TICKS);
         endcase
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 10'd1;
      end
   end

   always_comb begin
      run_d   = is_active(st_d) && !pause;
      lock_d  = is_active(st_d);
      fill_d  = run_d && ((st_d == ST_FILL) || (st_d == ST_RINSE));
      heat_d  = run_d && ((st_d == ST_HEAT) ||
                          ((st_d == ST_WASH) && (water_temp < heat_thr)));
      motor_d = run_d && ((st_d == ST_HEAT) || (st_d == ST_WASH) ||
                          (st_d == ST_RINSE) || (st_d == ST_SPIN));
      spin_d  = run_d && (st_d == ST_SPIN);
      drain_d = (run_d && (st_d == ST_SPIN)) || (st_d == ST_ERROR);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= ST_IDLE;
         cnt_q      <= '0;
         cxl_q      <= 1'b0;
         door_lock  <= 1'b0;
         fill_valve <= 1'b0;
         heater_on  <= 1'b0;
         motor_on   <= 1'b0;
         motor_spin <= 1'b0;
         drain_pump <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         cxl_q      <= cxl_d;
         door_lock  <= lock_d;
         fill_valve <= fill_d;
         heater_on  <= heat_d;
         motor_on   <= motor_d;
         motor_spin <= spin_d;
         drain_pump <= drain_d;
         done       <= (st_d == ST_DONE);
         error      <= (st_d == ST_ERROR);
      end
   end

   assign state     = st_q;
   assign remaining = cnt_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for the wash program controller: directed scenarios plus random
// stimulus, all run in lockstep with a phase-level reference model.
module tb_wash_cycle_sequencer;
   import wash_pkg::*;

   localparam int TD = 4, FT = 3, HT = 5, WT = 5, RT = 3, ST = 2, HY = 2;
   localparam int DUR [8] = '{0, FT, HT, WT, RT, ST, 0, 0};
   // {lock, fill, heat, motor, spin, drain} per phase
   localparam logic [5:0] ACT [8] = '{6'b000000, 6'b110000, 6'b101100, 6'b100100,
                                      6'b110100, 6'b100111, 6'b000000, 6'b000001};

   logic clk, reset_n, start, pause, cancel, door_closed, water_level_ok;
   logic [6:0] water_temp, target_temp;
   logic door_lock, fill_valve, heater_on, motor_on, motor_spin, drain_pump, done, error;
   logic [2:0] state;
   logic [9:0] remaining;

   wash_cycle_sequencer #(
      .TICK_DIV(TD), .FILL_TIMEOUT(FT), .HEAT_TIMEOUT(HT), .WASH_TICKS(WT),
      .RINSE_TICKS(RT), .SPIN_TICKS(ST), .HYST(HY)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .cancel(cancel),
      .door_closed(door_closed), .water_level_ok(water_level_ok),
      .water_temp(water_temp), .target_temp(target_temp),
      .door_lock(door_lock), .fill_valve(fill_valve), .heater_on(heater_on),
      .motor_on(motor_on), .motor_spin(motor_spin), .drain_pump(drain_pump),
      .done(done), .error(error), .state(state), .remaining(remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0, n_fails = 0, div_cnt = 0;
   logic [20:0] last_got, last_exp, m_vec;
   int m_ph, m_left, m_presc;
   bit m_cxl;

   function automatic logic [20:0] dut_vec();
      return {state, remaining, door_lock, fill_valve, heater_on, motor_on,
              motor_spin, drain_pump, done, error};
   endfunction

   task automatic model_reset();
      m_ph = 0; m_left = 0; m_presc = 0; m_cxl = 0; m_vec = '0;
   endtask

   // One clock of the program: phase rules by priority, then timer and outputs.
   task automatic model_step();
      int nph, thr;
      bit act, run, tick;
      logic [5:0] a;
      if (!reset_n) begin model_reset(); return; end
      nph  = m_ph;
      act  = (m_ph >= 1) && (m_ph <= 5);
      run  = act && !pause;
      tick = run && (m_presc == TD - 1);
      if (act && !door_closed) nph = 7;
      else if ((m_ph == 1 || m_ph == 2) && m_left == 0) nph = 7;
      else if (act && m_ph != 5 && (cancel || m_cxl)) begin
         m_cxl = 1;
         if (!pause) nph = 5;
      end else if (!(act && pause)) begin
         case (m_ph)
            0: if (start && door_closed) nph = 1;
            1: if (water_level_ok) nph = 2;
            2: if (water_temp >= target_temp) nph = 3;
            3, 4, 5: if (m_left == 0) nph = m_ph + 1;
            6: if (!door_closed) nph = 0; else if (start) nph = 1;
            7: if (cancel) nph = 0;
            default: ;
         endcase
      end
      if (run) m_presc = (m_presc + 1) % TD;
      if (nph != m_ph) begin m_cxl = 0; m_left = DUR[nph]; end
      else if (tick && m_left > 0) m_left--;
      m_ph = nph;
      a = ACT[nph];
      thr = int'(target_temp) - HY;
      if (thr < 0) thr = 0;
      if (nph == 3) a[3] = (int'(water_temp) < thr);
      if (nph >= 1 && nph <= 5 && pause) a = 6'b100000;
      m_vec = {3'(nph), 10'(m_left), a, nph == 6, nph == 7};
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (dut_vec() !== m_vec) begin
         div_cnt++; last_got = dut_vec(); last_exp = m_vec;
      end
   endtask

   task automatic do_reset();
      start = 0; pause = 0; cancel = 0; door_closed = 1; water_level_ok = 0;
      water_temp = 7'd20; target_temp = TEMP_40;
      reset_n = 0; cyc(); cyc(); reset_n = 1; cyc();
   endtask

   task automatic wait_state(input int s, input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         if (int'(state) == s) ok = 1; else cyc();
      end
      if (int'(state) == s) ok = 1;
   endtask

   task automatic test_reset();
      int div0 = div_cnt;
      start = 0; pause = 0; cancel = 0; door_closed = 1; water_level_ok = 0;
      water_temp = 7'd20; target_temp = TEMP_40;
      reset_n = 0; model_reset();
      cyc(); cyc();
      n_checks++;
      if (dut_vec() !== 21'd0) begin
         n_fails++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
      end
      reset_n = 1; cyc();
      n_checks++;
      if (state !== 3'd0 || remaining !== 10'd0) begin
         n_fails++; $display("FAIL reset_idle: state %0d rem %0d expected 0 0", state, remaining);
      end
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL reset_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_nominal();
      int div0 = div_cnt;
      int seq = 0, wseq = 0, last = -1, lastr = -1, fill_cyc = 0, heat_cyc = 0, lock_bad = 0;
      bit ok = 0;
      do_reset();
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (int'(state) != last) begin seq = seq * 10 + int'(state); last = int'(state); end
         if (state == 3'd3 && int'(remaining) != lastr) begin
            wseq = wseq * 10 + int'(remaining); lastr = int'(remaining);
         end
         if (state >= 3'd1 && state <= 3'd5 && door_lock !== 1'b1) lock_bad++;
         if (state == 3'd1) begin fill_cyc++; if (fill_cyc == 2 * TD) water_level_ok = 1; end
         if (state == 3'd2) begin heat_cyc++; if (heat_cyc == 6) water_temp = 7'd40; end
         if (state == 3'd6) ok = 1; else cyc();
      end
      n_checks++;
      if (!ok || done !== 1'b1) begin
         n_fails++; $display("FAIL nominal_done: state %0d done %b expected 6 1", state, done);
      end
      n_checks++;
      if (seq != 123456) begin
         n_fails++; $display("FAIL nominal_sequence: got %0d expected 123456", seq);
      end
      n_checks++;
      if (wseq != 543210) begin
         n_fails++; $display("FAIL nominal_wash_countdown: got %0d expected 543210", wseq);
      end
      n_checks++;
      if (lock_bad != 0 || door_lock !== 1'b0) begin
         n_fails++; $display("FAIL nominal_door_lock: %0d unlocked cycles, lock in DONE %b", lock_bad, door_lock);
      end
      water_level_ok = 0; door_closed = 0; cyc(); cyc();
      n_checks++;
      if (state !== 3'd0) begin
         n_fails++; $display("FAIL nominal_door_open_idle: state %0d expected 0", state);
      end
      door_closed = 1;
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL nominal_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_fill_timeout();
      int div0 = div_cnt;
      int n = 0, zero_at = -1;
      do_reset();
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 40 && state == 3'd1; i++) begin
         cyc(); n++;
         if (state == 3'd1 && remaining == 10'd0 && zero_at < 0) zero_at = n;
      end
      n_checks++;
      if (zero_at != 3 * TD || state !== 3'd7) begin
         n_fails++; $display("FAIL fill_timeout: zero after %0d clks state %0d expected %0d 7", zero_at, state, 3 * TD);
      end
      n_checks++;
      if ({error, drain_pump, fill_valve, door_lock, motor_on} !== 5'b11000) begin
         n_fails++; $display("FAIL fill_error_outputs: got %b expected 11000",
                             {error, drain_pump, fill_valve, door_lock, motor_on});
      end
      cancel = 1; cyc(); cancel = 0;
      n_checks++;
      if (state !== 3'd0 || error !== 1'b0) begin
         n_fails++; $display("FAIL error_cancel: state %0d error %b expected 0 0", state, error);
      end
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL fill_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_pause();
      int div0 = div_cnt;
      int bad = 0, dec = 0, lastr;
      bit ok;
      do_reset();
      water_temp = 7'd50; water_level_ok = 1; start = 1; cyc(); start = 0;
      wait_state(3, 60, ok);
      for (int i = 0; i < 40 && remaining != 10'd3; i++) cyc();
      n_checks++;
      if (!ok || state !== 3'd3 || remaining !== 10'd3) begin
         n_fails++; $display("FAIL pause_reach_wash: state %0d rem %0d expected 3 3", state, remaining);
      end
      pause = 1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (remaining !== 10'd3 || state !== 3'd3) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fails++; $display("FAIL pause_hold: %0d cycles moved, rem %0d expected 3", bad, remaining);
      end
      n_checks++;
      if ({door_lock, fill_valve, heater_on, motor_on, motor_spin, drain_pump} !== 6'b100000) begin
         n_fails++; $display("FAIL pause_actuators: got %b expected 100000",
                             {door_lock, fill_valve, heater_on, motor_on, motor_spin, drain_pump});
      end
      pause = 0; lastr = 3;
      for (int i = 0; i < 40 && state == 3'd3; i++) begin
         cyc();
         if (state == 3'd3 && int'(remaining) != lastr) begin dec++; lastr = int'(remaining); end
      end
      n_checks++;
      if (dec != 3 || state !== 3'd4) begin
         n_fails++; $display("FAIL pause_resume: %0d ticks then state %0d expected 3 then 4", dec, state);
      end
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL pause_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_hysteresis();
      int div0 = div_cnt;
      int tt [6] = '{40, 40, 40, 1, 60, 60};
      int tw [6] = '{39, 37, 38, 0, 57, 58};
      bit he [6] = '{0, 1, 0, 0, 1, 0};
      bit ok;
      do_reset();
      water_temp = 7'd45; water_level_ok = 1; start = 1; cyc(); start = 0;
      wait_state(3, 60, ok);
      for (int k = 0; k < 6; k++) begin
         target_temp = 7'(tt[k]); water_temp = 7'(tw[k]);
         cyc(); cyc();
         n_checks++;
         if (state !== 3'd3 || heater_on !== he[k]) begin
            n_fails++; $display("FAIL hysteresis_%0d: target %0d temp %0d heater %b state %0d expected %b 3",
                                k, tt[k], tw[k], heater_on, state, he[k]);
         end
      end
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL hysteresis_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_door_cancel();
      int div0 = div_cnt;
      bit ok;
      do_reset();
      water_temp = 7'd50; water_level_ok = 1; start = 1; cyc(); start = 0;
      wait_state(4, 150, ok);
      door_closed = 0; cyc();
      n_checks++;
      if (!ok || state !== 3'd7 || error !== 1'b1 || drain_pump !== 1'b1) begin
         n_fails++; $display("FAIL door_fault_rinse: state %0d error %b expected 7 1", state, error);
      end
      door_closed = 1; cancel = 1; cyc(); cancel = 0;
      target_temp = TEMP_60; water_temp = 7'd20; start = 1; cyc(); start = 0;
      wait_state(2, 30, ok);
      pause = 1; cancel = 1; cyc(); cancel = 0; cyc(); cyc(); cyc();
      n_checks++;
      if (!ok || state !== 3'd2 || door_lock !== 1'b1 || heater_on !== 1'b0) begin
         n_fails++; $display("FAIL cancel_while_paused: state %0d lock %b heat %b expected 2 1 0",
                             state, door_lock, heater_on);
      end
      pause = 0; cyc();
      n_checks++;
      if (state !== 3'd5 || remaining !== 10'(ST) || motor_spin !== 1'b1) begin
         n_fails++; $display("FAIL cancel_to_spin: state %0d rem %0d expected 5 %0d", state, remaining, ST);
      end
      wait_state(6, 40, ok);
      n_checks++;
      if (!ok || done !== 1'b1) begin
         n_fails++; $display("FAIL cancel_done: state %0d done %b expected 6 1", state, done);
      end
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL door_cancel_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_reset_mid_spin();
      int div0 = div_cnt;
      bit ok;
      do_reset();
      water_temp = 7'd50; water_level_ok = 1; start = 1; cyc(); start = 0;
      wait_state(5, 150, ok);
      #2 reset_n = 0;
      #1;
      n_checks++;
      if (!ok || dut_vec() !== 21'd0) begin
         n_fails++; $display("FAIL async_reset: got %h expected 0 (reached spin %b)", dut_vec(), ok);
      end
      model_reset();
      cyc(); reset_n = 1; cyc();
      door_closed = 0; start = 1; cyc(); cyc(); cyc();
      n_checks++;
      if (state !== 3'd0 || door_lock !== 1'b0) begin
         n_fails++; $display("FAIL start_door_open: state %0d expected 0", state);
      end
      start = 0; door_closed = 1;
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL reset_spin_lockstep: got %h expected %h", last_got, last_exp);
      end
   endtask

   task automatic test_random();
      int div0 = div_cnt;
      logic [6:0] tsel [4] = '{TEMP_10, TEMP_30, TEMP_40, TEMP_60};
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         door_closed    = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 24) == 0) pause = ~pause;
         cancel         = ($urandom_range(0, 99) == 0);
         start          = ($urandom_range(0, 9) == 0);
         water_level_ok = ($urandom_range(0, 5) == 0);
         water_temp     = 7'($urandom_range(0, 90));
         if ($urandom_range(0, 149) == 0) target_temp = tsel[$urandom_range(0, 3)];
         if ($urandom_range(0, 499) == 0) target_temp = 7'($urandom_range(0, 127));
         cyc();
      end
      pause = 0; cancel = 0; start = 0;
      n_checks++;
      if (div_cnt != div0) begin
         n_fails++; $display("FAIL random_lockstep: %0d cycles differ, last got %h expected %h",
                             div_cnt - div0, last_got, last_exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_fill_timeout();
      test_pause();
      test_hysteresis();
      test_door_cancel();
      test_reset_mid_spin();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
